// File: rtl/uart_rx_packer.sv
// uart_rx_packer: mid-bit-sampling UART receiver that packs bytes into FIFO_WR_WIDTH-bit words with idle-timeout flush.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (PARITY_ODD selects odd parity).
module uart_rx_packer #(
    parameter int UART_BPS      = 9600,
    parameter int CLK_FREQ      = 50_000_000,
    parameter int FIFO_WR_WIDTH = 32,
    parameter int MSB_FIRST     = 1,
    parameter int TIMEOUT_BITS  = 20
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD    = 1'b0
`endif
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  rx,
    input  logic                                  fifo_full,
    output logic [FIFO_WR_WIDTH-1:0]              fifo_wr_data,
    output logic                                  fifo_wr_en,
    output logic [$clog2(FIFO_WR_WIDTH/8+1)-1:0]  fifo_wr_bytes,
    output logic                                  frame_err,
    output logic                                  overflow_err,
    output logic                                  parity_err
);
    localparam int W            = FIFO_WR_WIDTH;
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int BYTE_NUM     = W / 8;
    localparam int CW           = $clog2(BYTE_NUM + 1);
    localparam int BW           = $clog2(BAUD_CNT_MAX + 1);
    localparam int TO_MAX       = TIMEOUT_BITS * BAUD_CNT_MAX;
    localparam int TW           = $clog2(TO_MAX + 2);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    localparam state_t S_POST_DATA = S_PARITY;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    localparam state_t S_POST_DATA = S_STOP;
`endif

    state_t          r_state, w_next;
    logic            r_rx_s1, r_rx_s2, r_rx_d;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_to;
    logic [W-1:0]    r_word;
    logic            w_fall, w_mid, w_stop_mid, w_par_bad, w_byte_vld, w_frame;
    logic            w_full, w_to_exp, w_emit;
    logic [CW-1:0]   w_pad;
    logic [W-1:0]    w_word_nx, w_part;

    always_ff @(posedge clk)
        if (!rst_n) {r_rx_s1, r_rx_s2, r_rx_d} <= 3'b111;
        else {r_rx_s1, r_rx_s2, r_rx_d} <= {rx, r_rx_s1, r_rx_s2};

    assign w_fall = r_rx_d && !r_rx_s2;
    assign w_mid  = r_baud == BW'(BAUD_CNT_MAX / 2);

    always_ff @(posedge clk)
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_next = S_START;
            S_START:  if (w_mid) w_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (w_mid && r_bit == 3'd7) w_next = S_POST_DATA;
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_mid) w_next = S_STOP;
`endif
            S_STOP:   if (w_mid) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic r_par, r_par_err;
    always_ff @(posedge clk)
        if (r_state == S_PARITY && w_mid) r_par <= r_rx_s2;
    assign w_par_bad = r_par != ((^r_shift) ^ PARITY_ODD);
    always_ff @(posedge clk)
        if (!rst_n) r_par_err <= 1'b0;
        else r_par_err <= w_stop_mid && w_par_bad;
    assign parity_err = r_par_err;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        w_stop_mid = r_state == S_STOP && w_mid;
        w_byte_vld = w_stop_mid && r_rx_s2 && !w_par_bad;
        w_frame    = w_stop_mid && !r_rx_s2;
    end

    // Baud counter and bit index only run while a frame is in progress.
    always_ff @(posedge clk)
        if (!rst_n || r_state == S_IDLE) begin
            r_baud <= '0;
            r_bit  <= '0;
        end else begin
            r_baud <= (r_baud == BW'(BAUD_CNT_MAX - 1)) ? '0 : r_baud + 1'b1;
            if (r_state == S_DATA && w_mid) begin
                r_shift <= {r_rx_s2, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
        end

    // Unused lanes of r_word stay zero, so OR-ing a byte into its lane is a plain write.
    assign w_pad     = CW'(BYTE_NUM) - r_cnt;
    assign w_word_nx = (MSB_FIRST != 0) ? ((r_word << 8) | W'(r_shift))
                                        : (r_word | (W'(r_shift) << {r_cnt, 3'b000}));
    assign w_part    = (MSB_FIRST != 0) ? (r_word << {w_pad, 3'b000}) : r_word;
    assign w_full    = w_byte_vld && r_cnt == CW'(BYTE_NUM - 1);
    assign w_to_exp  = (TO_MAX != 0) && r_cnt != '0 && !w_byte_vld && r_to == TW'(TO_MAX - 1);
    assign w_emit    = w_full || w_to_exp;

    always_ff @(posedge clk)
        if (!rst_n) begin
            r_cnt         <= '0;
            r_to          <= '0;
            r_word        <= '0;
            fifo_wr_en    <= 1'b0;
            fifo_wr_data  <= '0;
            fifo_wr_bytes <= '0;
            frame_err     <= 1'b0;
            overflow_err  <= 1'b0;
        end else begin
            frame_err    <= w_frame;
            fifo_wr_en   <= w_emit && !fifo_full;
            overflow_err <= w_emit && fifo_full;
            if (w_emit && !fifo_full) begin
                fifo_wr_data  <= w_full ? w_word_nx : w_part;
                fifo_wr_bytes <= w_full ? CW'(BYTE_NUM) : r_cnt;
            end
            r_to <= (w_byte_vld || w_to_exp || r_cnt == '0 || TO_MAX == 0) ? '0 : r_to + 1'b1;
            if (w_emit) begin
                r_cnt  <= '0;
                r_word <= '0;
            end else if (w_byte_vld) begin
                r_cnt  <= r_cnt + 1'b1;
                r_word <= w_word_nx;
            end
        end
endmodule

// File: tb/tb_uart_rx_packer.sv
// tb_uart_rx_packer: scoreboard bench driving one rx line into an MSB-first and an LSB-first packer.
module tb_uart_rx_packer;
    localparam int W   = 32;
    localparam int BIT = 10;
    localparam int TO  = 200;

    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, fifo_full = 1'b0;
    logic [W-1:0] d_a, d_b;
    logic [2:0]   n_a, n_b;
    logic         en_a, en_b, fe_a, fe_b, ov_a, ov_b, pe_a, pe_b;
    logic [W+2:0] q_a[$], q_b[$], e;
    logic [7:0]   pend[$];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, exp_fe = 0, exp_ov = 0;
    int wr_cyc = 0, start_cyc = 0, lat = 0;

    uart_rx_packer #(.UART_BPS(100_000), .CLK_FREQ(1_000_000), .FIFO_WR_WIDTH(W), .MSB_FIRST(1), .TIMEOUT_BITS(20)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx), .fifo_full(fifo_full), .fifo_wr_data(d_a), .fifo_wr_en(en_a),
        .fifo_wr_bytes(n_a), .frame_err(fe_a), .overflow_err(ov_a), .parity_err(pe_a));
    uart_rx_packer #(.UART_BPS(100_000), .CLK_FREQ(1_000_000), .FIFO_WR_WIDTH(W), .MSB_FIRST(0), .TIMEOUT_BITS(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx), .fifo_full(fifo_full), .fifo_wr_data(d_b), .fifo_wr_en(en_b),
        .fifo_wr_bytes(n_b), .frame_err(fe_b), .overflow_err(ov_b), .parity_err(pe_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (en_a) begin
            wr_cyc = cyc;
            if (q_a.size() == 0) chk("unexp_wr_a", en_a, 1'b0);
            else begin
                e = q_a.pop_front();
                chk("data_a", d_a, e[W-1:0]);
                chk("bytes_a", n_a, e[W+2:W]);
            end
        end
        if (en_b) begin
            if (q_b.size() == 0) chk("unexp_wr_b", en_b, 1'b0);
            else begin
                e = q_b.pop_front();
                chk("data_b", d_b, e[W-1:0]);
                chk("bytes_b", n_b, e[W+2:W]);
            end
        end
        fe_cnt += int'(fe_a) + int'(fe_b);
        ov_cnt += int'(ov_a) + int'(ov_b);
        pe_cnt += int'(pe_a) + int'(pe_b);
    end

    task automatic flush_model();
        logic [W-1:0] wa = '0, wb = '0;
        int n = pend.size();
        foreach (pend[i]) begin
            wa |= W'(pend[i]) << (8 * (3 - i));
            wb |= W'(pend[i]) << (8 * i);
        end
        if (fifo_full) exp_ov += 2;
        else begin
            q_a.push_back({3'(n), wa});
            q_b.push_back({3'(n), wb});
        end
        pend.delete();
    endtask

    task automatic tx(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^b;
        repeat (BIT) @(negedge clk);
`endif
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        pend.push_back(b);
        if (pend.size() == 4) flush_model();
        tx(b, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_en"}, {en_a, en_b}, 2'b00);
        chk({tag, "_data"}, {d_a, d_b}, 64'h0);
        chk({tag, "_bytes"}, {n_a, n_b}, 6'h0);
        chk({tag, "_errs"}, {fe_a, fe_b, ov_a, ov_b, pe_a, pe_b}, 6'h0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        // full words, back-to-back frames
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        repeat (5) @(negedge clk);
        lat = wr_cyc - start_cyc;
        chk("full_latency_range", (lat >= 95 && lat <= 105), 1'b1);
        // partial word flushed after the idle timeout
        send(8'hAB); send(8'hCD);
        flush_model();
        repeat (TO + 150) @(negedge clk);
        chk("timeout_latency", wr_cyc - start_cyc, lat + TO);
        // backpressure drops the word, next word goes through
        fifo_full = 1'b1;
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        repeat (5) @(negedge clk);
        fifo_full = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        // bad stop bit: error pulse, byte not counted
        tx(8'h55, 1'b0);
        exp_fe += 2;
        repeat (30) @(negedge clk);
        send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        // short low glitch on idle line
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        send(8'h5A); send(8'hA5); send(8'h3C); send(8'hC3);
        // reset in the middle of the third byte
        send(8'h77); send(8'h88);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT + 3) @(negedge clk);
        rst_n = 1'b0;
        pend.delete();
        repeat (3) @(negedge clk);
        check_reset("mid_rst");
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        send(8'h9A); send(8'hBC); send(8'hDE); send(8'hF0);
        repeat (TO + 50) @(negedge clk);
        chk("frame_err_pulses", fe_cnt, exp_fe);
        chk("overflow_pulses", ov_cnt, exp_ov);
        chk("parity_err_pulses", pe_cnt, 0);
        chk("pending_a", q_a.size(), 0);
        chk("pending_b", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
